// File: rtl/nonce_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : nonce_gen_if
//  Description : Control/data bundle between the nonce source and its host /
//                first m04 pipe stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface nonce_gen_if;
  logic        start;
  logic        hold;
  logic        found;
  logic [63:0] nonceStart;
  logic [63:0] nonceEnd;
  logic        vldOut;
  logic [63:0] m04Out;
  logic        busy;
  logic        done;
  logic        exhausted;
  logic [63:0] issuedCnt;

  // host / pipeline side
  modport master (
    output start, hold, found, nonceStart, nonceEnd,
    input  vldOut, m04Out, busy, done, exhausted, issuedCnt
  );

  // nonce generator side
  modport slave (
    input  start, hold, found, nonceStart, nonceEnd,
    output vldOut, m04Out, busy, done, exhausted, issuedCnt
  );
endinterface
`default_nettype wire

// File: rtl/nonce_gen.sv
`default_nettype none
// ============================================================================
//  Module      : nonce_gen
//  Description : Issues one 64-bit nonce per cycle from nonceStart to nonceEnd
//                (inclusive) in steps of STEP; stops on range exhaustion or a
//                found hit. Reports run status and issued count.
//  Revision    : 1.0  initial release
// ============================================================================
module nonce_gen #(
  parameter logic [31:0] STEP = 32'd1
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  nonce_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [63:0] cur, cur_nxt;
  logic [63:0] lim, lim_nxt;
  logic [63:0] cnt_nxt;
  logic [63:0] m04_nxt;
  logic        vld_nxt;
  logic        exh_nxt;
  logic [64:0] sum;

  // 65-bit sum so overflow past all-ones is visible instead of wrapping
  assign sum = {1'b0, cur} + {33'd0, STEP};

  // Next-state and next-output decode
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    lim_nxt   = lim;
    cnt_nxt   = bus.issuedCnt;
    m04_nxt   = bus.m04Out;
    vld_nxt   = 1'b0;
    exh_nxt   = bus.exhausted;

    unique case (state)
      IDLE, HALT: begin
        m04_nxt = 64'd0;
        if (bus.start) begin
          cur_nxt = bus.nonceStart;
          lim_nxt = bus.nonceEnd;
          cnt_nxt = 64'd0;
          if (bus.nonceStart > bus.nonceEnd) begin
            state_nxt = HALT;
            exh_nxt   = 1'b1;
          end else begin
            state_nxt = RUN;
            exh_nxt   = 1'b0;
          end
        end
      end
      RUN: begin
        if (bus.found) begin
          // a hit aborts even a pending final issue
          m04_nxt   = 64'd0;
          state_nxt = HALT;
          exh_nxt   = 1'b0;
        end else if (!bus.hold) begin
          vld_nxt = 1'b1;
          m04_nxt = cur;
          cnt_nxt = bus.issuedCnt + 64'd1;
          if (sum > {1'b0, lim} || sum[64]) begin
            state_nxt = HALT;
            exh_nxt   = 1'b1;
          end else begin
            cur_nxt = sum[63:0];
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cur           <= 64'd0;
      lim           <= 64'd0;
      bus.vldOut    <= 1'b0;
      bus.m04Out    <= 64'd0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.exhausted <= 1'b0;
      bus.issuedCnt <= 64'd0;
    end else begin
      state         <= state_nxt;
      cur           <= cur_nxt;
      lim           <= lim_nxt;
      bus.vldOut    <= vld_nxt;
      bus.m04Out    <= m04_nxt;
      bus.busy      <= (state_nxt == RUN);
      bus.done      <= (state_nxt == HALT);
      bus.exhausted <= exh_nxt;
      bus.issuedCnt <= cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nonce_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nonce_gen
//  Description : Scoreboard bench for nonce_gen, STEP=1 and STEP=4 instances.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nonce_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] q1[$];
  logic [63:0] q4[$];
  int   gap1 = 0;
  int   gap4 = 0;
  int   seen1 = 0;
  int   seen4 = 0;
  logic [63:0] e1, e4;

  nonce_gen_if if1 ();
  nonce_gen_if if4 ();

  nonce_gen #(.STEP(32'd1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  nonce_gen #(.STEP(32'd4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  always #5 clk = ~clk;

  // Output monitors: every valid nonce must match the scoreboard head
  always @(negedge clk) begin
    if (if1.vldOut) begin
      checks++;
      seen1++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL u1_unexpected_issue got=%h expected none", if1.m04Out);
      end else begin
        e1 = q1.pop_front();
        if (if1.m04Out !== e1) begin
          errors++;
          $display("FAIL u1_nonce got=%h expected=%h", if1.m04Out, e1);
        end
      end
    end else if (if1.busy && seen1 > 0) begin
      gap1++;
    end
    if (if4.vldOut) begin
      checks++;
      seen4++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL u4_unexpected_issue got=%h expected none", if4.m04Out);
      end else begin
        e4 = q4.pop_front();
        if (if4.m04Out !== e4) begin
          errors++;
          $display("FAIL u4_nonce got=%h expected=%h", if4.m04Out, e4);
        end
      end
    end else if (if4.busy && seen4 > 0) begin
      gap4++;
    end
    if (rst_n && (if1.busy && if1.done)) begin
      checks++;
      errors++;
      $display("FAIL u1_busy_done_both got=11 expected not both");
    end
  end

  // Reference model: expected issue sequence, truncated to maxn issues
  task automatic push_range(input int which, input logic [63:0] s, input logic [63:0] e,
                            input logic [63:0] step, input int maxn);
    logic [64:0] n;
    int k;
    n = {1'b0, s};
    k = 0;
    while (n <= {1'b0, e} && k < maxn) begin
      if (which == 1) q1.push_back(n[63:0]);
      else            q4.push_back(n[63:0]);
      n = n + {1'b0, step};
      k++;
    end
  endtask

  // Pulses start for one edge; returns at the negedge after that edge
  task automatic launch(input int which, input logic [63:0] s, input logic [63:0] e);
    @(negedge clk);
    if (which == 1) begin
      if1.nonceStart = s; if1.nonceEnd = e; if1.start = 1'b1;
      gap1 = 0; seen1 = 0;
    end else begin
      if4.nonceStart = s; if4.nonceEnd = e; if4.start = 1'b1;
      gap4 = 0; seen4 = 0;
    end
    @(negedge clk);
    if1.start = 1'b0;
    if4.start = 1'b0;
  endtask

  // Bounded wait for done, then one more cycle so the final issue drains
  task automatic wait_done(input int which);
    int i;
    for (i = 0; i < 200; i++) begin
      if ((which == 1) ? if1.done : if4.done) break;
      @(negedge clk);
    end
    checks++;
    if (i >= 200) begin
      errors++;
      $display("FAIL timeout_done unit=%0d got=0 expected=1", which);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({if1.vldOut, if1.busy, if1.done, if1.exhausted} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b expected=0000",
               {if1.vldOut, if1.busy, if1.done, if1.exhausted});
    end
    checks++;
    if (if1.m04Out !== 64'd0 || if1.issuedCnt !== 64'd0) begin
      errors++;
      $display("FAIL reset_data got=%h/%h expected=0/0", if1.m04Out, if1.issuedCnt);
    end
    checks++;
    if ({if4.vldOut, if4.busy, if4.done, if4.exhausted, if4.m04Out, if4.issuedCnt} !== '0) begin
      errors++;
      $display("FAIL reset_u4 got=nonzero expected=0");
    end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    push_range(1, 64'h10, 64'h13, 64'd1, 100);
    launch(1, 64'h10, 64'h13);
    checks++;
    if (if1.busy !== 1'b1 || if1.vldOut !== 1'b0) begin
      errors++;
      $display("FAIL start_latency got busy=%b vld=%b expected busy=1 vld=0", if1.busy, if1.vldOut);
    end
    @(negedge clk);
    checks++;
    if (if1.vldOut !== 1'b1 || if1.m04Out !== 64'h10) begin
      errors++;
      $display("FAIL first_issue got vld=%b m04=%h expected vld=1 m04=10", if1.vldOut, if1.m04Out);
    end
    wait_done(1);
    checks++;
    if (if1.exhausted !== 1'b1 || if1.issuedCnt !== 64'd4 || if1.vldOut !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got exh=%b cnt=%0d vld=%b expected 1/4/0",
               if1.exhausted, if1.issuedCnt, if1.vldOut);
    end
    checks++;
    if (gap1 !== 0 || q1.size() !== 0) begin
      errors++;
      $display("FAIL b2b_bubbles got gap=%0d left=%0d expected 0/0", gap1, q1.size());
    end
  endtask

  task automatic test_hold();
    push_range(1, 64'h10, 64'h13, 64'd1, 100);
    launch(1, 64'h10, 64'h13);
    repeat (2) @(negedge clk);
    if1.hold = 1'b1;
    repeat (2) @(negedge clk);
    if1.hold = 1'b0;
    wait_done(1);
    checks++;
    if (gap1 !== 2 || q1.size() !== 0) begin
      errors++;
      $display("FAIL hold_bubbles got gap=%0d left=%0d expected 2/0", gap1, q1.size());
    end
    checks++;
    if (if1.issuedCnt !== 64'd4 || if1.exhausted !== 1'b1) begin
      errors++;
      $display("FAIL hold_count got cnt=%0d exh=%b expected 4/1", if1.issuedCnt, if1.exhausted);
    end
  endtask

  task automatic test_found();
    push_range(1, 64'h0, 64'hFFFF, 64'd1, 5);
    launch(1, 64'h0, 64'hFFFF);
    repeat (5) @(negedge clk);
    if1.found = 1'b1;
    @(negedge clk);
    if1.found = 1'b0;
    checks++;
    if (if1.done !== 1'b1 || if1.exhausted !== 1'b0 || if1.issuedCnt !== 64'd5) begin
      errors++;
      $display("FAIL found_halt got done=%b exh=%b cnt=%0d expected 1/0/5",
               if1.done, if1.exhausted, if1.issuedCnt);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (if1.vldOut !== 1'b0 || q1.size() !== 0 || seen1 !== 5) begin
      errors++;
      $display("FAIL found_quiet got vld=%b issued=%0d expected 0/5", if1.vldOut, seen1);
    end
  endtask

  task automatic test_wrap();
    push_range(4, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'd4, 100);
    launch(4, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(4);
    repeat (3) @(negedge clk);
    checks++;
    if (if4.exhausted !== 1'b1 || if4.issuedCnt !== 64'd1 || seen4 !== 1 || q4.size() !== 0) begin
      errors++;
      $display("FAIL wrap got exh=%b cnt=%0d seen=%0d expected 1/1/1",
               if4.exhausted, if4.issuedCnt, seen4);
    end
  endtask

  task automatic test_empty_range();
    launch(1, 64'd5, 64'd3);
    checks++;
    if (if1.done !== 1'b1 || if1.busy !== 1'b0 || if1.exhausted !== 1'b1 || if1.issuedCnt !== 64'd0) begin
      errors++;
      $display("FAIL empty_range got done=%b busy=%b exh=%b cnt=%0d expected 1/0/1/0",
               if1.done, if1.busy, if1.exhausted, if1.issuedCnt);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (seen1 !== 0) begin
      errors++;
      $display("FAIL empty_issue got=%0d expected=0", seen1);
    end
  endtask

  task automatic test_reset_midrun();
    push_range(1, 64'h100, 64'h1FF, 64'd1, 3);
    launch(1, 64'h100, 64'h1FF);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({if1.vldOut, if1.busy, if1.done, if1.exhausted} !== 4'b0000 ||
        if1.m04Out !== 64'd0 || if1.issuedCnt !== 64'd0) begin
      errors++;
      $display("FAIL midrun_reset got vld=%b busy=%b m04=%h cnt=%0d expected all 0",
               if1.vldOut, if1.busy, if1.m04Out, if1.issuedCnt);
    end
    checks++;
    if (seen1 !== 3 || q1.size() !== 0) begin
      errors++;
      $display("FAIL midrun_issued got=%0d expected=3", seen1);
    end
    rst_n = 1'b1;
    push_range(1, 64'h20, 64'h21, 64'd1, 100);
    launch(1, 64'h20, 64'h21);
    wait_done(1);
    checks++;
    if (if1.issuedCnt !== 64'd2 || if1.exhausted !== 1'b1 || q1.size() !== 0) begin
      errors++;
      $display("FAIL relaunch got cnt=%0d exh=%b left=%0d expected 2/1/0",
               if1.issuedCnt, if1.exhausted, q1.size());
    end
  endtask

  initial begin
    if1.start = 1'b0; if1.hold = 1'b0; if1.found = 1'b0;
    if1.nonceStart = '0; if1.nonceEnd = '0;
    if4.start = 1'b0; if4.hold = 1'b0; if4.found = 1'b0;
    if4.nonceStart = '0; if4.nonceEnd = '0;
    test_reset();
    test_back_to_back();
    test_hold();
    test_found();
    test_wrap();
    test_empty_range();
    test_reset_midrun();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nonce_gen.md
Name: nonce_gen

Overview:
- Nonce source that sits directly upstream of the first m04 pipeline stage of the Sia miner datapath.
- On a start pulse it issues one 64-bit nonce word (m04) per cycle into the pipe chain, from nonceStart to nonceEnd in increments of STEP.
- It stops when the range is exhausted or when `found` reports a hit.
- It also reports run status and the count of issued nonces, so the host can relaunch or bookkeep.

Parameters:
- STEP, 1, nonce increment per issue (multi-core interleave stride); legal range 1..2^32-1.

Ports:
- clk  input  1  core clock; all state updates on the rising edge
- rst_n  input  1  synchronous reset, active-low
- start  input  1  launch pulse; samples nonceStart/nonceEnd
- hold  input  1  stall request; suppresses issue for that cycle
- found  input  1  nonce-found indication from the hash checker; aborts the run
- nonceStart  input  64  first nonce of the range
- nonceEnd  input  64  last nonce allowed (inclusive)
- vldOut  output  1  m04Out is valid this cycle; drives vldIn of the first pipe stage
- m04Out  output  64  nonce word; drives m04In of the first pipe stage
- busy  output  1  high while state is RUN
- done  output  1  high while state is HALT
- exhausted  output  1  in HALT: 1 = range exhausted, 0 = stopped by found
- issuedCnt  output  64  number of vldOut=1 cycles since the last accepted start

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE.
  - vldOut=0, m04Out=0, busy=0, done=0, exhausted=0, issuedCnt=0.
  - Internal cur=0, lim=0.
  - Reset mid-run aborts immediately; nothing is issued on the next cycle.
- All outputs are registered.
- States: IDLE, RUN, HALT.
- IDLE:
  - vldOut=0.
  - start=1: cur<=nonceStart, lim<=nonceEnd, issuedCnt<=0, exhausted<=0.
    - If nonceStart>nonceEnd (unsigned): go to HALT with exhausted=1; no nonce is issued.
    - Otherwise go to RUN.
  - found is ignored.
- RUN (evaluated each edge, priority order):
  1. found=1: vldOut<=0, m04Out<=0, go to HALT, exhausted<=0. found wins over hold and over a final issue in the same cycle.
  2. hold=1: vldOut<=0; m04Out, cur and issuedCnt unchanged.
  3. Otherwise issue:
     - vldOut<=1, m04Out<=cur, issuedCnt<=issuedCnt+1.
     - Compute nxt = {1'b0,cur}+STEP as 65 bits.
     - If nxt>{1'b0,lim} or nxt[64]=1: go to HALT, exhausted<=1. The current nonce is still issued.
     - Otherwise cur<=nxt[63:0].
  - start in RUN is ignored.
- HALT:
  - vldOut<=0, m04Out<=0.
  - done=1; exhausted and issuedCnt hold their values.
  - start=1 relaunches exactly as from IDLE (same cycle behaviour, done drops).
  - found is ignored.
- Latency:
  - start sampled at edge k → busy=1 after edge k.
  - The first vldOut=1 with m04Out=nonceStart appears after edge k+1, if no hold or found occurs at k+1.
- Back-to-back issue: with hold=0 there is one nonce per cycle and no bubbles.
- Range is inclusive: nonceStart=nonceEnd issues exactly one nonce.
- Wrap-around: cur never wraps; overflow of the 64-bit range ends the run as exhausted.
- busy, done and state are mutually consistent:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - HALT: busy=0, done=1.

Test Plan:
- Reset then start with nonceStart=0x10, nonceEnd=0x13, STEP=1 → m04Out 0x10,0x11,0x12,0x13 on 4 consecutive vldOut cycles starting edge k+1; then done=1, exhausted=1, issuedCnt=4, vldOut=0.
- Same range with hold=1 for 2 cycles after the second issue → m04Out sequence unchanged with exactly 2 vldOut=0 bubbles; issuedCnt=4.
- nonceStart=0, nonceEnd=0xFFFF, found pulsed on the cycle the 6th issue would occur → 5 nonces (0..4) issued; HALT with exhausted=0, issuedCnt=5; vldOut stays 0.
- nonceStart=0xFFFF_FFFF_FFFF_FFFE, nonceEnd=all-ones, STEP=4 → exactly one issue (…FE), then exhausted=1 with no wrap to 0x2.
- nonceStart=5, nonceEnd=3 → HALT after edge k, exhausted=1, no vldOut ever asserted, issuedCnt=0.
- rst_n=0 during RUN after 3 issues → next cycle all outputs 0, state IDLE; a subsequent start relaunches from the new nonceStart.
